// File: rtl/mul_ctrl_if.sv
// Exe-stage <-> multiplier controller signal bundle.
// slave: the controller itself; master: the pipeline / multiplier side.
interface mul_ctrl_if;
  logic        valid_i;
  logic        is_mul_i;
  logic        flush_i;
  logic [31:0] data_rs1_i;
  logic [31:0] data_rs2_i;
  logic [31:0] mul_res_i;
  logic        mul_start_o;
  logic [31:0] mul_rs1_o;
  logic [31:0] mul_rs2_o;
  logic        stall_o;
  logic        done_o;
  logic [31:0] res_o;
  logic        busy_o;

  modport slave (
    input  valid_i, is_mul_i, flush_i, data_rs1_i, data_rs2_i, mul_res_i,
    output mul_start_o, mul_rs1_o, mul_rs2_o, stall_o, done_o, res_o, busy_o
  );

  modport master (
    output valid_i, is_mul_i, flush_i, data_rs1_i, data_rs2_i, mul_res_i,
    input  mul_start_o, mul_rs1_o, mul_rs2_o, stall_o, done_o, res_o, busy_o
  );
endinterface

// File: rtl/mul_ctrl.sv
// Multi-cycle multiplier sequencer for the exe stage: latches operands,
// pulses start, waits MUL_LATENCY cycles, captures the product and
// reports done for one cycle while stalling the front of the pipeline.
module mul_ctrl #(
  parameter int unsigned MUL_LATENCY = 3
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  mul_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAT = 4'(MUL_LATENCY);

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] rs1_q;
  logic [31:0] rs2_q;
  logic [31:0] res_q;
  logic        request;

  assign request = bus.valid_i & bus.is_mul_i & ~bus.flush_i;

  // Sequencer: operand latch, latency countdown, product capture; flush aborts to IDLE
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= IDLE;
      cnt   <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      res_q <= '0;
    end else if (bus.flush_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (request) begin
            rs1_q <= bus.data_rs1_i;
            rs2_q <= bus.data_rs2_i;
            cnt   <= LAT;
            state <= BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            res_q <= bus.mul_res_i;
            state <= DONE;
          end
        end
        // Leave unconditionally: the instruction advances this cycle, so it must not retrigger
        DONE: begin
          cnt   <= '0;
          state <= IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Outputs decoded from registered state; unknown encodings decode to all-zero
  always_comb begin
    bus.busy_o      = (state == BUSY);
    bus.mul_start_o = (state == BUSY) && (cnt == LAT);
    bus.stall_o     = ~bus.flush_i & (((state == IDLE) & request) | (state == BUSY));
    bus.done_o      = ~bus.flush_i & (state == DONE);
  end

  assign bus.mul_rs1_o = rs1_q;
  assign bus.mul_rs2_o = rs2_q;
  assign bus.res_o     = res_q;

endmodule

// File: doc/mul_ctrl.md
MUL_CTRL -- requirements
Module: mul_ctrl

Interface
REQ-001 SHALL have parameter MUL_LATENCY, default 3, meaning cycles from mul_start_o to a valid mul_res_i, counted inclusive; legal range 1..15.
REQ-002 SHALL have port clk_i  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rstn_i  input  1  asynchronous active-low reset.
REQ-004 SHALL have port valid_i  input  1  instruction in exe is valid.
REQ-005 SHALL have port is_mul_i  input  1  the exe instruction needs the multiplier.
REQ-006 SHALL have port flush_i  input  1  kill the exe instruction and any in-flight multiply.
REQ-007 SHALL have port data_rs1_i  input  32  operand A from exe.
REQ-008 SHALL have port data_rs2_i  input  32  operand B from exe.
REQ-009 SHALL have port mul_res_i  input  32  product from the multiplier unit.
REQ-010 SHALL have port mul_start_o  output  1  one-cycle start pulse to the multiplier.
REQ-011 SHALL have port mul_rs1_o  output  32  latched operand A to the multiplier.
REQ-012 SHALL have port mul_rs2_o  output  32  latched operand B to the multiplier.
REQ-013 SHALL have port stall_o  output  1  hold fetch/decode/exe this cycle.
REQ-014 SHALL have port done_o  output  1  res_o holds the product for the exe instruction this cycle.
REQ-015 SHALL have port res_o  output  32  registered product.
REQ-016 SHALL have port busy_o  output  1  state is BUSY.

Function
REQ-017 SHALL implement states IDLE, BUSY, DONE plus a 4-bit down-counter cnt.
REQ-018 request = valid_i & is_mul_i & ~flush_i, SHALL only be evaluated in IDLE.
REQ-019 IDLE with request SHALL latch data_rs1_i/data_rs2_i into mul_rs1_o/mul_rs2_o, load cnt = MUL_LATENCY and go to BUSY; without request it SHALL stay in IDLE.
REQ-020 mul_start_o SHALL be 1 only in BUSY with cnt == MUL_LATENCY, i.e. exactly once per operation, one cycle after the request cycle.
REQ-021 BUSY SHALL decrement cnt each cycle; with cnt == 1 it SHALL capture mul_res_i into res_o and go to DONE.
REQ-022 DONE SHALL assert done_o for exactly one cycle and go to IDLE unconditionally, so the same instruction cannot retrigger.
REQ-023 stall_o SHALL be combinational: (IDLE & request) | BUSY; it SHALL be 0 in DONE.
REQ-024 mul_rs1_o/mul_rs2_o SHALL hold stable from the BUSY entry until the next request; operand changes on data_rs*_i during BUSY SHALL be ignored.
REQ-025 Timing with request in cycle T: mul_start_o at T+1, mul_res_i sampled at end of T+MUL_LATENCY, done_o at T+MUL_LATENCY+1; stall_o high for T..T+MUL_LATENCY (MUL_LATENCY+1 cycles).
REQ-026 MUL_LATENCY == 1 SHALL give start and sample in the same BUSY cycle (combinational multiplier).
REQ-027 flush_i in any state SHALL force stall_o = 0 and done_o = 0 in that cycle and next state IDLE; res_o and operand registers SHALL keep their values.
REQ-028 flush_i and request in the same IDLE cycle SHALL start no operation.
REQ-029 A request in the cycle after DONE SHALL start a new operation with no bubble.
REQ-030 Unreachable state encodings SHALL return to IDLE next cycle with all outputs deasserted.

Reset
REQ-031 rstn_i low SHALL immediately set state IDLE, cnt 0, res_o 0, mul_rs1_o 0, mul_rs2_o 0, so mul_start_o, stall_o (absent a request), done_o and busy_o are 0.
REQ-032 Reset mid-operation SHALL abandon it; no done_o SHALL follow reset release.

Verification
REQ-033 MUL_LATENCY=3, request at T with rs1=7, rs2=6, mul_res_i=42 at T+3 -> mul_start_o at T+1 only, stall_o high T..T+3, done_o and res_o=42 at T+4.
REQ-034 data_rs1_i changed to 9 at T+2 -> mul_rs1_o stays 7, res_o reflects the latched operands.
REQ-035 flush_i at T+2 -> stall_o 0 at T+2, IDLE at T+3, no done_o, no second mul_start_o.
REQ-036 Back-to-back requests at T and T+5 -> two done_o pulses at T+4 and T+9, zero idle cycles between operations.
REQ-037 rstn_i low at T+2 -> all outputs 0 immediately; after release with no request, no done_o ever.
REQ-038 MUL_LATENCY=1, request at T -> mul_start_o and sampling at T+1, done_o at T+2, stall_o high for T..T+1.
